pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-fetch and program-counter sequencer. It drives the instruction-memory read
//  handshake, presents each fetched instruction to the opcode decoder, and consumes the
//  decoder's jump/bzero/bnegative/HLT/mainAddress/enable outputs to pick the next PC.
//  It also holds the ALU zero/negative flag register that conditional branches test.
// PARAMETERS
//  ADDR_WIDTH   10  PC / instruction-memory address width (matches decoder mainAddress)
//  INSTR_WIDTH  32  instruction word width; opcode = instr[INSTR_WIDTH-1 -: 6]
//  RESET_PC     0   PC value loaded on reset
// PORTS
//  clock        in   1    single clock, rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  imemReq      out  1    read request to instruction memory, one-cycle pulse
//  imemAddr     out  AW   read address; valid while imemReq=1
//  imemValid    in   1    instruction data valid; arbitrary latency >=1 cycle after imemReq
//  imemData     in   IW   instruction word; sampled when imemValid=1
//  instruction  out  IW   latched current instruction, to the decoder
//  operation    out  6    opcode field of instruction
//  instrValid   out  1    1 while instruction is in the EXEC state
//  pc           out  AW   address of the current instruction
//  jump         in   1    decoder: unconditional jump
//  bzero        in   1    decoder: branch if zero flag set
//  bnegative    in   1    decoder: branch if negative flag set
//  HLT          in   1    decoder: halt
//  mainAddress  in   AW   decoder: branch/jump target
//  enable       in   1    decoder: capture ALU flags this instruction
//  aluZero      in   1    ALU result == 0
//  aluNegative  in   1    ALU result sign bit
//  stall        in   1    hold current instruction in EXEC (I/O or memory wait)
//  resume       in   1    leave HALTED; level-sampled
//  halted       out  1    1 in HALTED state
//  zeroFlag     out  1    registered zero flag
//  negativeFlag out  1    registered negative flag
// BEHAVIOUR
//  Reset (async, reset_n=0): state=FETCH, pc=RESET_PC, instruction=0, imemReq=0,
//   instrValid=0, halted=0, zeroFlag=0, negativeFlag=0. Release resumes at the next edge.
//  FSM states: FETCH -> WAIT -> EXEC -> (FETCH | HALTED); HALTED -> FETCH.
//  FETCH: imemReq=1, imemAddr=pc for exactly one cycle; next state WAIT.
//  WAIT: imemReq=0; on imemValid=1 latch imemData into instruction, then EXEC.
//   imemValid outside WAIT is ignored.
//  EXEC: instrValid=1. The decoder is combinational, so its outputs are valid this cycle.
//   stall=1: remain in EXEC; pc, instruction and flags hold; no flag capture.
//   stall=0: resolve the next PC with fixed priority, then go to FETCH:
//    1 HLT            -> pc=pc+1, state=HALTED
//    2 jump           -> pc=mainAddress
//    3 bzero&zeroFlag -> pc=mainAddress
//    4 bnegative&negativeFlag -> pc=mainAddress
//    5 otherwise      -> pc=pc+1
//   Branches test the flags as registered before this edge, i.e. the flags set by an
//   earlier enable=1 instruction (pre-branch).
//   On the same edge, if enable=1: zeroFlag<=aluZero, negativeFlag<=aluNegative.
//  HALTED: halted=1, instrValid=0, imemReq=0; resume=1 -> FETCH at the next edge.
//   resume in any other state is ignored.
//  Width rules: pc+1 wraps modulo 2^ADDR_WIDTH (max -> 0). mainAddress is used unextended.
//  Minimum cycles per instruction: 3 (FETCH, WAIT with 1-cycle memory, EXEC).
//  Reset mid-operation: any state returns to FETCH at RESET_PC; an in-flight memory
//   response arriving after reset is discarded (not in WAIT).
// STRUCTURE
//  Shared package: state encodings (S_FETCH/S_WAIT/S_EXEC/S_HALTED), OPCODE_MSB/width
//   constant, RESET_PC default.
//  One natural sub-module: flag_register (enable-gated capture of zero/negative, async
//   reset). Next-PC priority mux stays inline.
// TESTING
//  1 Reset, then 1-cycle memory returns non-branch opcodes -> pc 0,1,2; imemReq every 3 cycles.
//  2 jump=1, mainAddress=10'h155 in EXEC -> next imemAddr=10'h155.
//  3 enable=1 with aluZero=1, then bzero=1 with target 10'h020 -> pc=10'h020.
//    Repeat with aluZero=0 captured -> pc=pc+1.
//  4 HLT at pc=10'h007 -> halted=1, no imemReq for 20 cycles;
//    resume=1 -> fetch at 10'h008.
//  5 pc=10'h3FF, non-branch -> next fetch 10'h000.
//    stall=1 for 5 cycles -> instrValid held, pc unchanged.
//  6 reset_n low during WAIT, late imemValid after release -> ignored; fetch at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Imported by the sequencer top and its flag register.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_e;

  localparam int OPCODE_W         = 6;
  localparam int RESET_PC_DEFAULT = 0;

  function automatic int opcode_msb(input int iw);
    return iw - 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_flag_register.sv
// ALU zero/negative flag register, captured only when the
// executing instruction asks for it.
module flag_register
  import pc_sequencer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_capture,
  input  logic i_zero,
  input  logic i_negative,
  output logic o_zero,
  output logic o_negative
);

  logic r_zero;
  logic r_negative;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (i_capture) begin
      r_zero     <= i_zero;
      r_negative <= i_negative;
    end
  end

  assign o_zero     = r_zero;
  assign o_negative = r_negative;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch / PC sequencer: memory handshake, instruction
// latch, next-PC priority resolution and halt/resume control.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imemReq,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemValid,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [OPCODE_W-1:0]    operation,
  output logic                   instrValid,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   jump,
  input  logic                   bzero,
  input  logic                   bnegative,
  input  logic                   HLT,
  input  logic [ADDR_WIDTH-1:0]  mainAddress,
  input  logic                   enable,
  input  logic                   aluZero,
  input  logic                   aluNegative,
  input  logic                   stall,
  input  logic                   resume,
  output logic                   halted,
  output logic                   zeroFlag,
  output logic                   negativeFlag
);

  state_e                 r_state;
  state_e                 w_next;
  logic                   r_live;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] w_instr_next;
  pc_sel_e                w_sel;
  logic                   w_flag_cap;
  logic                   w_zero;
  logic                   w_neg;

  // r_live keeps FETCH quiet during reset and the first edge after release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_sel        = PC_HOLD;
    w_instr_next = r_instr;
    w_flag_cap   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (r_live) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imemValid) begin
          w_instr_next = imemData;
          w_next       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          w_flag_cap = enable;
          w_next     = S_FETCH;
          // branches see the flags registered before this edge
          if (HLT) begin
            w_sel  = PC_INC;
            w_next = S_HALTED;
          end else if (jump) begin
            w_sel = PC_TARGET;
          end else if (bzero && w_zero) begin
            w_sel = PC_TARGET;
          end else if (bnegative && w_neg) begin
            w_sel = PC_TARGET;
          end else begin
            w_sel = PC_INC;
          end
        end
      end
      S_HALTED: begin
        if (resume) w_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    case (w_sel)
      PC_INC:    w_pc_next = r_pc + ADDR_WIDTH'(1);
      PC_TARGET: w_pc_next = mainAddress;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= ADDR_WIDTH'(RESET_PC);
      r_instr <= '0;
    end else begin
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
    end
  end

  flag_register u_flags (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_capture  (w_flag_cap),
    .i_zero     (aluZero),
    .i_negative (aluNegative),
    .o_zero     (w_zero),
    .o_negative (w_neg)
  );

  assign imemReq      = (r_state == S_FETCH) && r_live;
  assign imemAddr     = r_pc;
  assign pc           = r_pc;
  assign instruction  = r_instr;
  assign operation    = r_instr[opcode_msb(INSTR_WIDTH) -: OPCODE_W];
  assign instrValid   = (r_state == S_EXEC);
  assign halted       = (r_state == S_HALTED);
  assign zeroFlag     = w_zero;
  assign negativeFlag = w_neg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: the bench plays memory and decoder and
// predicts every fetch address from the next-PC rules.
module tb_pc_sequencer;

  localparam int AW = 10;
  localparam int IW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemValid = 1'b0;
  logic [IW-1:0] imemData = '0;
  logic [IW-1:0] instruction;
  logic [5:0]    operation;
  logic          instrValid;
  logic [AW-1:0] pc;
  logic          jump = 1'b0;
  logic          bzero = 1'b0;
  logic          bnegative = 1'b0;
  logic          HLT = 1'b0;
  logic [AW-1:0] mainAddress = '0;
  logic          enable = 1'b0;
  logic          aluZero = 1'b0;
  logic          aluNegative = 1'b0;
  logic          stall = 1'b0;
  logic          resume = 1'b0;
  logic          halted;
  logic          zeroFlag;
  logic          negativeFlag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_req = 0;
  int last_gap = 0;

  logic [AW-1:0] m_pc;
  logic          m_z;
  logic          m_n;

  typedef struct {
    bit jmp, bz, bn, hlt, en, az, an;
    logic [AW-1:0] tgt;
    int stall_n;
    int lat;
    logic [IW-1:0] data;
  } op_t;

  typedef struct {
    bit to;
    bit held_ok;
    logic ev;
    logic [AW-1:0] addr;
    logic [AW-1:0] pc_ex;
    logic [IW-1:0] ins;
    logic [5:0] op;
  } obs_t;

  pc_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData),
    .instruction(instruction), .operation(operation),
    .instrValid(instrValid), .pc(pc),
    .jump(jump), .bzero(bzero), .bnegative(bnegative),
    .HLT(HLT), .mainAddress(mainAddress), .enable(enable),
    .aluZero(aluZero), .aluNegative(aluNegative),
    .stall(stall), .resume(resume), .halted(halted),
    .zeroFlag(zeroFlag), .negativeFlag(negativeFlag)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (reset_n && imemReq === 1'b1) begin
      last_gap = cyc - last_req;
      last_req = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic op_t plain(input logic [IW-1:0] d);
    op_t o;
    o.jmp = 0; o.bz = 0; o.bn = 0; o.hlt = 0;
    o.en = 0; o.az = 0; o.an = 0;
    o.tgt = '0; o.stall_n = 0; o.lat = 1; o.data = d;
    return o;
  endfunction

  // Next PC from the decoder's priority rules, flags as of before this op
  task automatic model_step(input op_t o);
    if (o.hlt) m_pc = m_pc + 1'b1;
    else if (o.jmp) m_pc = o.tgt;
    else if (o.bz && m_z) m_pc = o.tgt;
    else if (o.bn && m_n) m_pc = o.tgt;
    else m_pc = m_pc + 1'b1;
    if (o.en) begin
      m_z = o.az;
      m_n = o.an;
    end
  endtask

  task automatic clear_decoder();
    jump = 0; bzero = 0; bnegative = 0; HLT = 0;
    enable = 0; aluZero = 0; aluNegative = 0;
    mainAddress = AW'($urandom());
  endtask

  task automatic run_instr(input op_t o, output obs_t r);
    int n;
    logic [AW-1:0] pc0;
    logic [IW-1:0] i0;
    r.to = 0; r.held_ok = 1; r.ev = 0;
    r.addr = '0; r.pc_ex = '0; r.ins = '0; r.op = '0;
    n = 0;
    while (imemReq !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (imemReq !== 1'b1) begin
      r.to = 1;
      return;
    end
    r.addr = imemAddr;
    repeat (o.lat) @(negedge clock);
    imemValid = 1;
    imemData = o.data;
    @(negedge clock);
    imemValid = 0;
    imemData = $urandom();
    r.ev = instrValid;
    r.ins = instruction;
    r.op = operation;
    r.pc_ex = pc;
    jump = o.jmp; bzero = o.bz; bnegative = o.bn; HLT = o.hlt;
    mainAddress = o.tgt; enable = o.en;
    aluZero = o.az; aluNegative = o.an;
    pc0 = pc;
    i0 = instruction;
    for (int k = 0; k < o.stall_n; k++) begin
      stall = 1;
      @(negedge clock);
      if (instrValid !== 1'b1 || pc !== pc0 || instruction !== i0)
        r.held_ok = 0;
    end
    stall = 0;
    @(negedge clock);
    clear_decoder();
  endtask

  task automatic test_reset();
    reset_n = 0;
    imemValid = 1;
    imemData = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    checks++;
    if ({imemReq, instrValid, halted, zeroFlag, negativeFlag} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 00000",
        {imemReq, instrValid, halted, zeroFlag, negativeFlag}); end
    checks++;
    if (pc !== 10'h000)
      begin errors++; $display("FAIL reset_pc: got %h want 000", pc); end
    checks++;
    if (instruction !== 32'h0)
      begin errors++; $display("FAIL reset_instr: got %h want 0", instruction); end
    imemValid = 0;
    reset_n = 1;
    m_pc = '0; m_z = 0; m_n = 0;
  endtask

  task automatic test_sequential();
    op_t o;
    obs_t r;
    for (int i = 0; i < 3; i++) begin
      o = plain({6'h01 + 6'(i), 26'($urandom())});
      run_instr(o, r);
      checks++;
      if (r.to || r.addr !== AW'(i))
        begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, r.addr, AW'(i)); end
      checks++;
      if (r.ev !== 1'b1 || r.ins !== o.data || r.op !== o.data[31:26] || r.pc_ex !== r.addr)
        begin errors++; $display("FAIL seq_instr%0d: got %h/%h ev=%b want %h", i, r.ins, r.op, r.ev, o.data); end
      model_step(o);
    end
    checks++;
    if (last_gap !== 3)
      begin errors++; $display("FAIL req_period: got %0d want 3", last_gap); end
  endtask

  task automatic test_jump();
    op_t o;
    obs_t r;
    o = plain($urandom());
    o.jmp = 1; o.tgt = 10'h155;
    run_instr(o, r);
    model_step(o);
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h155)
      begin errors++; $display("FAIL jump_addr: got %h want 155", r.addr); end
    model_step(plain(0));
  endtask

  task automatic test_branches();
    op_t o;
    obs_t r;
    logic [AW-1:0] pb;
    o = plain($urandom()); o.en = 1; o.az = 1; o.an = 0;
    run_instr(o, r); model_step(o);
    checks++;
    if (zeroFlag !== 1'b1 || negativeFlag !== 1'b0)
      begin errors++; $display("FAIL flag_capture: got z=%b n=%b want z=1 n=0", zeroFlag, negativeFlag); end
    o = plain($urandom()); o.bz = 1; o.tgt = 10'h020;
    run_instr(o, r); model_step(o);
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h020)
      begin errors++; $display("FAIL bzero_taken: got %h want 020", r.addr); end
    model_step(plain(0));
    o = plain($urandom()); o.en = 1; o.az = 0; o.an = 1;
    run_instr(o, r); model_step(o);
    o = plain($urandom()); o.bz = 1; o.tgt = 10'h020;
    run_instr(o, r); model_step(o);
    pb = r.addr;
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== pb + 10'd1)
      begin errors++; $display("FAIL bzero_not_taken: got %h want %h", r.addr, pb + 10'd1); end
    model_step(plain(0));
    o = plain($urandom()); o.bn = 1; o.tgt = 10'h2C3;
    run_instr(o, r); model_step(o);
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h2C3)
      begin errors++; $display("FAIL bneg_taken: got %h want 2c3", r.addr); end
    model_step(plain(0));
  endtask

  task automatic test_halt();
    op_t o;
    obs_t r;
    int nreq;
    o = plain($urandom()); o.jmp = 1; o.tgt = 10'h007;
    run_instr(o, r); model_step(o);
    o = plain($urandom()); o.hlt = 1; o.jmp = 1; o.tgt = 10'h100;
    run_instr(o, r); model_step(o);
    checks++;
    if (r.to || r.addr !== 10'h007)
      begin errors++; $display("FAIL halt_at: got %h want 007", r.addr); end
    checks++;
    if (halted !== 1'b1 || instrValid !== 1'b0)
      begin errors++; $display("FAIL halted_state: got h=%b v=%b want h=1 v=0", halted, instrValid); end
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (imemReq !== 1'b0) nreq++;
    end
    checks++;
    if (nreq != 0 || halted !== 1'b1)
      begin errors++; $display("FAIL halt_quiet: got req=%0d h=%b want 0 1", nreq, halted); end
    resume = 1;
    @(negedge clock);
    resume = 0;
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h008)
      begin errors++; $display("FAIL resume_addr: got %h want 008", r.addr); end
    model_step(plain(0));
  endtask

  task automatic test_wrap_and_stall();
    op_t o;
    obs_t r;
    o = plain($urandom()); o.jmp = 1; o.tgt = 10'h3FF;
    run_instr(o, r); model_step(o);
    run_instr(plain($urandom()), r); model_step(plain(0));
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h000)
      begin errors++; $display("FAIL pc_wrap: got %h want 000", r.addr); end
    model_step(plain(0));
    o = plain($urandom()); o.stall_n = 5; o.jmp = 1; o.tgt = 10'h2A5; o.lat = 3;
    run_instr(o, r); model_step(o);
    checks++;
    if (!r.held_ok || r.ins !== o.data)
      begin errors++; $display("FAIL stall_hold: got held=%0d want 1", r.held_ok); end
    run_instr(plain($urandom()), r);
    checks++;
    if (r.to || r.addr !== 10'h2A5)
      begin errors++; $display("FAIL after_stall: got %h want 2a5", r.addr); end
    model_step(plain(0));
  endtask

  task automatic test_random();
    op_t o;
    obs_t r;
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      o = plain($urandom());
      o.jmp = ($urandom_range(0, 4) == 0);
      o.bz = ($urandom_range(0, 2) == 0);
      o.bn = ($urandom_range(0, 2) == 0);
      o.en = $urandom_range(0, 1);
      o.az = $urandom_range(0, 1);
      o.an = $urandom_range(0, 1);
      o.tgt = AW'($urandom());
      o.lat = $urandom_range(1, 3);
      o.stall_n = $urandom_range(0, 2);
      resume = $urandom_range(0, 1);
      run_instr(o, r);
      checks++;
      if (r.to || r.addr !== m_pc || r.ins !== o.data || !r.held_ok) begin
        errors++;
        bad++;
        $display("FAIL rand%0d: got %h/%h want %h/%h", i, r.addr, r.ins, m_pc, o.data);
      end
      model_step(o);
      if (bad > 3) break;
    end
    resume = 0;
  endtask

  task automatic test_reset_midop();
    op_t o;
    obs_t r;
    o = plain($urandom()); o.jmp = 1; o.tgt = 10'h123; o.en = 1; o.az = 1; o.an = 1;
    run_instr(o, r);
    @(negedge clock);
    #2;
    reset_n = 0;
    imemValid = 1;
    imemData = 32'hBAD0_BAD0;
    @(negedge clock);
    checks++;
    if (pc !== 10'h000 || imemReq !== 1'b0 || zeroFlag !== 1'b0 || negativeFlag !== 1'b0)
      begin errors++; $display("FAIL midop_reset: got pc=%h req=%b z=%b n=%b want 000 0 0 0",
        pc, imemReq, zeroFlag, negativeFlag); end
    reset_n = 1;
    m_pc = '0; m_z = 0; m_n = 0;
    @(negedge clock);
    imemValid = 0;
    o = plain(32'h1234_5678);
    run_instr(o, r);
    checks++;
    if (r.to || r.addr !== 10'h000 || r.ins !== 32'h1234_5678)
      begin errors++; $display("FAIL late_valid: got %h/%h want 000/12345678", r.addr, r.ins); end
    model_step(o);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_sequential();
    test_jump();
    test_branches();
    test_halt();
    test_wrap_and_stall();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
